// File: rtl/food_gen.sv
// food_gen: food placement engine for the snake game.
//   Random candidates come from a free-running Galois LFSR. Candidates outside
//   the GRID_W x GRID_H grid are rejected. In-range candidates are checked
//   against the snake body through a one-cycle occupancy query (occ_req ->
//   occ_hit one cycle later). After MAX_TRY random draws the engine falls back
//   to a raster scan. If the scan finds no free cell, grid_full is set.
// Ports:
//   clk, rst (asynchronous, active-low)
//   game_state  2'b01 = playing
//   get_food    snake ate food (one-cycle pulse)
//   occ_req/occ_x/occ_y/occ_hit  occupancy query handshake
//   food_x/food_y/food_valid     committed food position
//   busy        generation in progress
//   grid_full   scan found no free cell (sticky until reset)
//   food_bonus  current food is bonus food
// Optional feature: define FOOD_BONUS_EN for bonus food with a BONUS_TICKS
//   lifetime. Without it food_bonus is tied low and no timer exists.
module food_gen #(
  parameter int unsigned       GRID_W  = 32,
  parameter int unsigned       GRID_H  = 24,
  parameter int unsigned       XW      = 5,
  parameter int unsigned       YW      = 5,
  parameter int unsigned       LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
  parameter int unsigned       MAX_TRY = 8
`ifdef FOOD_BONUS_EN
  , parameter int unsigned     BONUS_TICKS = 1000000
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    game_state,
  input  logic          get_food,
  output logic          occ_req,
  output logic [XW-1:0] occ_x,
  output logic [YW-1:0] occ_y,
  input  logic          occ_hit,
  output logic [XW-1:0] food_x,
  output logic [YW-1:0] food_y,
  output logic          food_valid,
  output logic          busy,
  output logic          grid_full,
  output logic          food_bonus
);

  function automatic logic [LFSR_W-1:0] taps_for(input int unsigned w);
    logic [63:0] t;
    case (w)
      8:       t = 64'hB8;
      9:       t = 64'h110;
      10:      t = 64'h240;
      11:      t = 64'h500;
      12:      t = 64'hE08;
      13:      t = 64'h1C80;
      14:      t = 64'h3802;
      15:      t = 64'h6000;
      17:      t = 64'h12000;
      18:      t = 64'h20400;
      19:      t = 64'h72000;
      20:      t = 64'h90000;
      24:      t = 64'hE10000;
      32:      t = 64'hA3000000;
      default: t = 64'hB400;
    endcase
    return t[LFSR_W-1:0];
  endfunction

  localparam logic [LFSR_W-1:0] TAPS    = taps_for(LFSR_W);
  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam int unsigned       NCELL   = GRID_W * GRID_H;
  localparam int unsigned       SW      = $clog2(NCELL + 1);
  localparam int unsigned       TW      = $clog2(MAX_TRY + 1);
  localparam logic [XW:0]       GW      = (XW+1)'(GRID_W);
  localparam logic [YW:0]       GH      = (YW+1)'(GRID_H);
  localparam logic [TW-1:0]     MT      = TW'(MAX_TRY);
  localparam logic [SW-1:0]     NC      = SW'(NCELL);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAW, S_QUERY, S_WAIT, S_SCAN_Q, S_SCAN_W
  } state_t;

  state_t            r_state;
  logic [LFSR_W-1:0] r_lfsr;
  logic [TW-1:0]     r_try;
  logic [SW-1:0]     r_scan;
  logic              r_occ_req;
  logic [XW-1:0]     r_occ_x;
  logic [YW-1:0]     r_occ_y;
  logic [XW-1:0]     r_food_x;
  logic [YW-1:0]     r_food_y;
  logic              r_food_valid;
  logic              r_grid_full;
  logic              r_food_bonus;

  logic [LFSR_W-1:0] w_lfsr_nxt;
  logic [XW-1:0]     w_cand_x;
  logic [YW-1:0]     w_cand_y;
  logic              w_in_range;
  logic              w_playing;
  logic              w_start;
  logic              w_commit;
  logic [TW-1:0]     w_try_inc;
  logic [XW:0]       w_nx1;
  logic [YW:0]       w_ny1;
  logic [XW-1:0]     w_next_x;
  logic [YW-1:0]     w_next_y;

  assign w_lfsr_nxt = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? TAPS : '0);
  assign w_cand_x   = r_lfsr[XW-1:0];
  assign w_cand_y   = r_lfsr[XW+YW-1:XW];
  assign w_in_range = ({1'b0, w_cand_x} < GW) && ({1'b0, w_cand_y} < GH);
  assign w_playing  = (game_state == 2'b01);
  assign w_try_inc  = r_try + TW'(1);
  assign w_commit   = w_playing && !occ_hit &&
                      ((r_state == S_WAIT) || (r_state == S_SCAN_W));

`ifdef FOOD_BONUS_EN
  localparam int unsigned BTW = (BONUS_TICKS < 2) ? 1 : $clog2(BONUS_TICKS + 1);
  logic [BTW-1:0] r_bonus_tmr;
  logic           w_bonus_exp;
  // An expiring bonus restarts generation unless get_food is handled this cycle.
  assign w_bonus_exp = r_food_bonus && (r_bonus_tmr == '0) && !get_food;
  assign w_start = w_playing &&
                   (get_food || (!r_food_valid && !r_grid_full) || w_bonus_exp);
`else
  assign w_start = w_playing && (get_food || (!r_food_valid && !r_grid_full));
`endif

  // Next cell in raster order, wrapping x into y and y back to row 0.
  always_comb begin
    w_nx1    = {1'b0, r_occ_x} + (XW+1)'(1);
    w_ny1    = {1'b0, r_occ_y} + (YW+1)'(1);
    w_next_x = w_nx1[XW-1:0];
    w_next_y = r_occ_y;
    if (w_nx1 == GW) begin
      w_next_x = '0;
      w_next_y = (w_ny1 == GH) ? '0 : w_ny1[YW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_lfsr       <= SEED_NZ;
      r_try        <= '0;
      r_scan       <= '0;
      r_occ_req    <= 1'b0;
      r_occ_x      <= '0;
      r_occ_y      <= '0;
      r_food_x     <= '0;
      r_food_y     <= '0;
      r_food_valid <= 1'b0;
      r_grid_full  <= 1'b0;
      r_food_bonus <= 1'b0;
`ifdef FOOD_BONUS_EN
      r_bonus_tmr  <= '0;
`endif
    end else begin
      r_lfsr    <= w_lfsr_nxt;
      r_occ_req <= 1'b0;
      if (!w_playing && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_food_valid <= 1'b0;
              r_food_bonus <= 1'b0;
              r_try        <= '0;
              r_state      <= S_DRAW;
            end
          end
          S_DRAW: begin
            if (w_in_range) begin
              r_occ_x   <= w_cand_x;
              r_occ_y   <= w_cand_y;
              r_occ_req <= 1'b1;
              r_state   <= S_QUERY;
            end else begin
              r_try <= w_try_inc;
              if (w_try_inc == MT) begin
                r_occ_x   <= '0;
                r_occ_y   <= '0;
                r_scan    <= SW'(1);
                r_occ_req <= 1'b1;
                r_state   <= S_SCAN_Q;
              end
            end
          end
          S_QUERY:  r_state <= S_WAIT;
          S_WAIT: begin
            if (!occ_hit) begin
              r_state <= S_IDLE;
            end else begin
              r_try <= w_try_inc;
              if (w_try_inc == MT) begin
                r_occ_x   <= w_next_x;
                r_occ_y   <= w_next_y;
                r_scan    <= SW'(1);
                r_occ_req <= 1'b1;
                r_state   <= S_SCAN_Q;
              end else begin
                r_state <= S_DRAW;
              end
            end
          end
          S_SCAN_Q: r_state <= S_SCAN_W;
          S_SCAN_W: begin
            if (!occ_hit) begin
              r_state <= S_IDLE;
            end else if (r_scan == NC) begin
              r_grid_full <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_scan    <= r_scan + SW'(1);
              r_occ_x   <= w_next_x;
              r_occ_y   <= w_next_y;
              r_occ_req <= 1'b1;
              r_state   <= S_SCAN_Q;
            end
          end
          default:  r_state <= S_IDLE;
        endcase
      end
      if (w_commit) begin
        r_food_x     <= r_occ_x;
        r_food_y     <= r_occ_y;
        r_food_valid <= 1'b1;
      end
`ifdef FOOD_BONUS_EN
      if (w_playing && (r_bonus_tmr != '0))
        r_bonus_tmr <= r_bonus_tmr - BTW'(1);
      if (w_commit) begin
        r_food_bonus <= &r_lfsr[LFSR_W-1 -: 3];
        r_bonus_tmr  <= BTW'(BONUS_TICKS);
      end
`endif
    end
  end

  assign occ_req    = r_occ_req;
  assign occ_x      = r_occ_x;
  assign occ_y      = r_occ_y;
  assign food_x     = r_food_x;
  assign food_y     = r_food_y;
  assign food_valid = r_food_valid;
  assign grid_full  = r_grid_full;
  assign busy       = (r_state != S_IDLE);
  assign food_bonus = r_food_bonus;

endmodule

// File: tb/tb_food_gen.sv
// Self-checking bench for food_gen (default build, bonus feature disabled).
// The reference model predicts, per generation, the list of occupancy
// queries (cycle, x, y) and the final outcome from the LFSR sequence and the
// placement rules; the occupancy responder answers from a chosen hit policy.
module tb_food_gen;

  localparam int GW      = 32;
  localparam int GH      = 24;
  localparam int MAX_TRY = 8;
  localparam int NARR    = 24000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] game_state;
  logic       get_food;
  logic       occ_req;
  logic [4:0] occ_x, occ_y;
  logic       occ_hit;
  logic [4:0] food_x, food_y;
  logic       food_valid, busy, grid_full, food_bonus;

  food_gen #(
    .GRID_W(32), .GRID_H(24), .XW(5), .YW(5), .LFSR_W(16),
    .SEED(16'hACE1), .MAX_TRY(8)
  ) dut (
    .clk(clk), .rst(rst), .game_state(game_state), .get_food(get_food),
    .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .busy(busy),
    .grid_full(grid_full), .food_bonus(food_bonus)
  );

  always #5 clk = ~clk;

  // Number of rising edges since reset release.
  int cyc;
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  typedef struct { int at; int x; int y; } q_t;

  q_t          exp_q[$];
  logic [15:0] lfsr_arr [NARR];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          mode, k_hits, free_x, free_y, resp_idx;
  logic        hit_pend;
  int          exp_done, exp_fx, exp_fy, last_fx, last_fy;
  bit          exp_full;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // 0: never hit, 1: hit the first k_hits queries, 2: only (free_x,free_y) free, 3: always hit
  function automatic bit hit_policy(input int idx, input int x, input int y);
    case (mode)
      1:       return idx < k_hits;
      2:       return !(x == free_x && y == free_y);
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic scan_model(input int qe, input int lin0, input int qi0);
    int lin = lin0;
    int qi = qi0;
    int at = qe;
    q_t e;
    for (int cnt = 1; cnt <= GW*GH; cnt++) begin
      e.at = at; e.x = lin % GW; e.y = lin / GW;
      exp_q.push_back(e);
      if (!hit_policy(qi, e.x, e.y)) begin
        exp_done = at + 2; exp_full = 0; exp_fx = e.x; exp_fy = e.y;
        return;
      end
      qi++;
      lin = (lin + 1) % (GW*GH);
      at += 2;
    end
    exp_done = at; exp_full = 1;
  endtask

  // Start condition sampled at edge e0; DRAW examines the LFSR value left by the previous edge.
  task automatic predict(input int e0);
    int t = e0 + 1;
    int tries = 0;
    int qi = 0;
    q_t e;
    logic [15:0] v;
    exp_q.delete();
    for (int g = 0; g < 200; g++) begin
      v = lfsr_arr[t-1];
      e.at = t; e.x = int'(v[4:0]); e.y = int'(v[9:5]);
      if (e.x < GW && e.y < GH) begin
        exp_q.push_back(e);
        if (!hit_policy(qi, e.x, e.y)) begin
          exp_done = t + 2; exp_full = 0; exp_fx = e.x; exp_fy = e.y;
          return;
        end
        qi++; tries++;
        if (tries == MAX_TRY) begin
          scan_model(t + 2, (e.y*GW + e.x + 1) % (GW*GH), qi);
          return;
        end
        t += 3;
      end else begin
        tries++;
        if (tries == MAX_TRY) begin
          scan_model(t, 0, qi);
          return;
        end
        t += 1;
      end
    end
  endtask

  // One clock: occupancy responder plus query monitor, sampled at the falling edge.
  task automatic tick();
    q_t e;
    @(negedge clk);
    if (rst) begin
      occ_hit  = hit_pend;
      hit_pend = 1'b0;
      if (occ_req) begin
        hit_pend = hit_policy(resp_idx, int'(occ_x), int'(occ_y));
        resp_idx++;
        if (exp_q.size() == 0) check("occ_req_extra", occ_req, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("occ_req_cycle", cyc, e.at);
          check("occ_x", occ_x, e.x);
          check("occ_y", occ_y, e.y);
        end
      end
    end
  endtask

  task automatic run_gen(input string tag, input int m, input bit via_food);
    int e0, guard;
    mode = m; resp_idx = 0;
    e0 = cyc + 1;
    if (via_food) get_food = 1'b1;
    else          game_state = 2'b01;
    predict(e0);
    tick();
    get_food = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    guard = 0;
    while (cyc < exp_done - 1 && guard < 4000) begin tick(); guard++; end
    if (guard >= 4000) check({tag, "_timeout"}, cyc, exp_done - 1);
    check({tag, "_valid_early"}, food_valid, 1'b0);
    tick();
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_valid"}, food_valid, !exp_full);
    check({tag, "_full"}, grid_full, exp_full);
    check({tag, "_bonus"}, food_bonus, 1'b0);
    check({tag, "_queries_left"}, exp_q.size(), 0);
    if (!exp_full) begin
      last_fx = exp_fx; last_fy = exp_fy;
    end
    check({tag, "_food_x"}, food_x, last_fx);
    check({tag, "_food_y"}, food_y, last_fy);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e0, k, q, m;
    lfsr_arr[0] = 16'hACE1;
    for (int i = 1; i < NARR; i++) lfsr_arr[i] = lfsr_step(lfsr_arr[i-1]);
    rst = 1'b0; game_state = 2'b00; get_food = 1'b0; occ_hit = 1'b0; hit_pend = 1'b0;
    mode = 0; k_hits = 0; free_x = 0; free_y = 0; resp_idx = 0;
    last_fx = 0; last_fy = 0;

    repeat (2) @(negedge clk);
    check("rst_food_valid", food_valid, 1'b0);
    check("rst_food_x", food_x, 0);
    check("rst_food_y", food_y, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_grid_full", grid_full, 1'b0);
    check("rst_occ_req", occ_req, 1'b0);
    check("rst_food_bonus", food_bonus, 1'b0);
    rst = 1'b1;

    // First food is placed automatically on entering play.
    run_gen("auto", 0, 0);
    k_hits = 7;
    run_gen("hit7", 1, 1);
    free_x = 31; free_y = 23;
    run_gen("last_cell", 2, 1);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 4)) tick();
      m = int'($urandom_range(0, 2));
      k_hits = int'($urandom_range(0, 7));
      free_x = int'($urandom_range(0, GW-1));
      free_y = int'($urandom_range(0, GH-1));
      run_gen($sformatf("rand%0d", i), m, 1);
    end

    // Busy get_food is ignored; leaving play aborts and holds the old position.
    mode = 3; resp_idx = 0;
    e0 = cyc + 1;
    get_food = 1'b1;
    predict(e0);
    tick();
    get_food = 1'b0;
    check("abort_busy", busy, 1'b1);
    repeat (3) tick();
    get_food = 1'b1;
    tick();
    get_food = 1'b0;
    repeat (12) tick();
    check("abort_still_busy", busy, 1'b1);
    k = cyc;
    game_state = 2'b10;
    while (exp_q.size() > 0 && exp_q[$].at > k) void'(exp_q.pop_back());
    tick();
    check("abort_busy_low", busy, 1'b0);
    check("abort_valid", food_valid, 1'b0);
    check("abort_occ_req", occ_req, 1'b0);
    check("abort_food_x", food_x, last_fx);
    check("abort_food_y", food_y, last_fy);
    repeat (5) tick();
    check("idle_hold_busy", busy, 1'b0);
    check("idle_hold_valid", food_valid, 1'b0);
    check("idle_hold_food_x", food_x, last_fx);
    check("idle_hold_food_y", food_y, last_fy);
    check("abort_queries_left", exp_q.size(), 0);
    run_gen("restart", 0, 0);

    // Every cell occupied: scan covers the whole grid then reports full.
    run_gen("full", 3, 1);
    repeat (5) tick();
    check("full_sticky", grid_full, 1'b1);
    check("full_no_restart", busy, 1'b0);
    check("full_valid", food_valid, 1'b0);

    // Asynchronous reset in the middle of a WAIT cycle.
    mode = 0; resp_idx = 0;
    e0 = cyc + 1;
    get_food = 1'b1;
    predict(e0);
    q = exp_q[0].at;
    tick();
    get_food = 1'b0;
    for (int g = 0; g < 50 && cyc < q + 1; g++) tick();
    check("rstw_pre_busy", busy, 1'b1);
    check("rstw_pre_full", grid_full, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rstw_busy", busy, 1'b0);
    check("rstw_valid", food_valid, 1'b0);
    check("rstw_full", grid_full, 1'b0);
    check("rstw_food_x", food_x, 0);
    check("rstw_food_y", food_y, 0);
    check("rstw_occ_req", occ_req, 1'b0);
    game_state = 2'b00;
    exp_q.delete();
    hit_pend = 1'b0;
    occ_hit = 1'b0;
    last_fx = 0; last_fy = 0;
    @(negedge clk);
    rst = 1'b1;
    run_gen("post_reset", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/food_gen.md
Name: food_gen

Overview:
- Parametrised food placement engine for the snake game. It replaces the fixed 32x24 random placer.
- Draws candidate cells from a free-running LFSR and rejects any candidate outside the grid.
- Checks each in-range candidate against the snake body through an occupancy query handshake. After a bounded number of random tries it falls back to a deterministic scan.
- Sits between the snake body/collision logic (occupancy source) and the VGA renderer (food_x/food_y consumer).

Parameters:
- GRID_W, 32, grid width in cells (2..2^XW)
- GRID_H, 24, grid height in cells (2..2^YW)
- XW, 5, food_x width
- YW, 5, food_y width
- LFSR_W, 16, LFSR width; XW+YW+3 <= LFSR_W required
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 1
- MAX_TRY, 8, random draws (in-range and out-of-range) before scan fallback
- BONUS_TICKS, 1000000, bonus food lifetime in cycles (only with FOOD_BONUS_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- game_state  in  2  2'b01 = playing; any other value = not playing
- get_food  in  1  snake ate food; one-cycle pulse
- occ_req  out  1  occupancy query strobe, high for one cycle
- occ_x  out  XW  queried cell x
- occ_y  out  YW  queried cell y
- occ_hit  in  1  the queried cell is snake body; valid exactly one cycle after occ_req
- food_x  out  XW  food cell x
- food_y  out  YW  food cell y
- food_valid  out  1  food position committed and displayable
- busy  out  1  generation in progress (state != IDLE)
- grid_full  out  1  scan found no free cell; sticky until reset
- food_bonus  out  1  current food is bonus food

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; food_x=0, food_y=0.
  - food_valid=0, grid_full=0, food_bonus=0, occ_req=0, try counter=0.
  - LFSR=SEED.
- LFSR:
  - 16-bit Galois, taps 16'hB400 (for other LFSR_W, a maximal-length tap constant).
  - Advances every cycle regardless of state.
  - cand_x = lfsr[XW-1:0]; cand_y = lfsr[XW+YW-1:XW].
- States: IDLE, DRAW, QUERY, WAIT, SCAN_Q, SCAN_W.
- IDLE:
  - Generation starts when game_state==01 and either (get_food==1) or (food_valid==0 and grid_full==0).
  - The second condition auto-places the first food on entering play.
  - On start: food_valid<=0, try<=0, go to DRAW.
- DRAW:
  - If cand_x<GRID_W and cand_y<GRID_H: latch the candidate into occ_x/occ_y, go to QUERY.
  - Otherwise: try<=try+1; if try+1==MAX_TRY, start a scan from (0,0); else stay in DRAW.
- QUERY:
  - occ_req=1 for this cycle only; go to WAIT.
- WAIT (samples occ_hit):
  - hit=0: commit food_x/food_y<=occ_x/occ_y, food_valid<=1, go to IDLE.
  - hit=1: try<=try+1.
    - If try+1==MAX_TRY: go to SCAN_Q at (occ_x+1, occ_y), wrapping x at GRID_W into y+1, and y at GRID_H into 0. Scan counter = 1.
    - Otherwise go back to DRAW.
- SCAN_Q / SCAN_W:
  - Same query/commit handshake as QUERY/WAIT.
  - On a hit, step to the next cell in raster order with wrap, and increment the scan counter.
  - When the scan counter reaches GRID_W*GRID_H with all cells hit: grid_full<=1, food_valid stays 0, go to IDLE.
- Latency, best case: get_food sampled at edge E0; DRAW at E1; occ_req high between E1 and E2; occ_hit sampled and food_valid=1 after E3.
- get_food while busy is ignored; no queuing.
- game_state leaving 01 while busy: abort to IDLE at the next edge. food_valid stays 0 and food_x/food_y hold. On re-entering play, auto-generation restarts.
- Not playing and IDLE: all outputs hold.
- food_x/food_y change only on commit or reset.
- Widths: compare against GRID_W/GRID_H at XW+1/YW+1 bits. The scan counter is wide enough for GRID_W*GRID_H.

Optional Feature:
- Macro: FOOD_BONUS_EN.
- Defined:
  - On commit, food_bonus<=1 if lfsr[LFSR_W-1:LFSR_W-3]==3'b111, else 0.
  - A bonus timer loads BONUS_TICKS on commit and decrements only while game_state==01.
  - On reaching 0 with food_bonus=1 and no get_food that cycle: food_bonus<=0 and generation auto-restarts.
  - get_food in the same cycle takes priority; food_bonus clears on the next start.
- Undefined: food_bonus is tied to 0, and no timer logic is present.

Test Plan:
- Reset, then game_state=01, occ_hit always 0, SEED=16'hACE1 -> food_valid rises within 3+MAX_TRY cycles; food_x<32, food_y<24; occ_req pulses exactly once per accepted query.
- occ_hit=1 for the first 7 queries, then 0 -> food committed at the 8th queried cell; no scan entered.
- occ_hit=1 for all random draws, free cell only at (31,23), GRID_W=32, GRID_H=24 -> scan wraps correctly; food_x=31, food_y=23.
- occ_hit=1 for every query -> after 768 scan queries, grid_full=1, food_valid=0, busy=0.
- get_food pulse while busy, and game_state=2'b10 mid-generation -> second request ignored; abort to IDLE; food_valid=0; position held. Assert rst=0 during WAIT -> outputs reset immediately, without waiting for a clock edge.
- FOOD_BONUS_EN, BONUS_TICKS=10, forced bonus draw -> food_bonus=1, and a new placement starts after 10 playing cycles; with game_state paused, the timer freezes.
